// File: rtl/asrv32_lsu_pkg.sv
// Shared encodings for the ASRV32 load/store unit: access sizes, FSM states
// and the alignment rule used to reject accesses before they reach the bus.
package asrv32_lsu_pkg;

  // Access size encodings as presented by the memory stage.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is also handled as a word

  // Bus initiator FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // A halfword must sit on an even address, a word on a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = addr_lo[0];
      default:   is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/asrv32_lsu_align.sv
// Combinational lane logic: replicates store data across byte lanes with a
// matching byte mask, and extracts/extends load data from the bus word.
module asrv32_lsu_align
  import asrv32_lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_lane_data,
  output logic [3:0]  st_mask,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store steering: replicate the LSB-justified datum on every lane it may use.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // the block leaves it unassigned and no latch is inferred.
    st_lane_data = st_wdata;
    st_mask      = 4'b1111;
    case (st_size)
      SIZE_BYTE: begin
        st_lane_data = {4{st_wdata[7:0]}};
        st_mask      = 4'b0001 << st_addr_lo;
      end
      SIZE_HALF: begin
        st_lane_data = {2{st_wdata[15:0]}};
        st_mask      = 4'b0011 << {st_addr_lo[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Load extraction: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    ld_byte = 8'h00;
    case (ld_addr_lo)
      2'd0: ld_byte = bus_rdata[7:0];
      2'd1: ld_byte = bus_rdata[15:8];
      2'd2: ld_byte = bus_rdata[23:16];
      2'd3: ld_byte = bus_rdata[31:24];
      default: ;
    endcase
    ld_half = ld_addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ld_size)
      SIZE_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default:   ld_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/asrv32_lsu.sv
// ASRV32 load/store bus initiator: accepts one request at a time, issues a
// single-cycle strobe on the stb/ack bus, waits for acknowledge or timeout,
// and returns extended load data with a one-cycle completion pulse.
module asrv32_lsu
  import asrv32_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic        o_stb_data,
  output logic [31:0] o_data_addr,
  output logic [31:0] o_wdata,
  output logic        o_wr_en,
  output logic [3:0]  o_wr_mask,
  input  logic [31:0] i_rdata,
  input  logic        i_ack_data
);

  localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [1:0]    addr_lo_q;

  logic [31:0]   st_lane_data;
  logic [3:0]    st_mask;
  logic [31:0]   ld_data;

  // Store lanes come from the request being accepted; load extraction uses
  // the attributes captured at accept time.
  asrv32_lsu_align u_align (
    .st_size      (i_size),
    .st_addr_lo   (i_addr[1:0]),
    .st_wdata     (i_wdata),
    .st_lane_data (st_lane_data),
    .st_mask      (st_mask),
    .ld_size      (size_q),
    .ld_addr_lo   (addr_lo_q),
    .ld_unsigned  (uns_q),
    .bus_rdata    (i_rdata),
    .ld_data      (ld_data)
  );

  // Ready is the only output decoded straight from state.
  assign o_ready = (state == ST_IDLE);

  // FSM, timeout counter and all registered outputs.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      size_q       <= SIZE_BYTE;
      uns_q        <= 1'b0;
      addr_lo_q    <= 2'b00;
      o_done       <= 1'b0;
      o_misaligned <= 1'b0;
      o_timeout    <= 1'b0;
      o_stb_data   <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_mask    <= 4'b0000;
      o_rdata      <= 32'h0;
      o_wdata      <= 32'h0;
      o_data_addr  <= 32'h0;
    end else begin
      // Completion flags are pulses unless re-asserted below.
      o_done       <= 1'b0;
      o_misaligned <= 1'b0;
      o_timeout    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            we_q      <= i_we;
            size_q    <= i_size;
            uns_q     <= i_unsigned;
            addr_lo_q <= i_addr[1:0];
            if (is_misaligned(i_size, i_addr[1:0])) begin
              // Rejected without touching the bus; o_rdata keeps its value.
              o_done       <= 1'b1;
              o_misaligned <= 1'b1;
            end else begin
              state       <= ST_REQ;
              o_stb_data  <= 1'b1;
              o_wr_en     <= i_we;
              o_wr_mask   <= st_mask;
              o_wdata     <= st_lane_data;
              o_data_addr <= {i_addr[31:2], 2'b00};
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          // The strobe lasts exactly the REQ cycle.
          o_stb_data <= 1'b0;
          o_wr_en    <= 1'b0;
          o_wr_mask  <= 4'b0000;
          if (i_ack_data) begin
            state  <= ST_IDLE;
            o_done <= 1'b1;
            if (!we_q) o_rdata <= ld_data;
          end else if (state == ST_REQ) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_IDLE;
            o_done    <= 1'b1;
            o_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asrv32_lsu.sv
// Directed self-checking bench for asrv32_lsu with a small bus responder
// (none / registered-ack RAM / combinational-ack RAM) driven from tick().
module tb_asrv32_lsu;
  import asrv32_lsu_pkg::*;

  localparam int TC = 4;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic        i_unsigned = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic [31:0] i_rdata = 32'h0;
  logic        i_ack_data = 1'b0;
  logic        o_ready, o_done, o_misaligned, o_timeout, o_stb_data, o_wr_en;
  logic [31:0] o_rdata, o_data_addr, o_wdata;
  logic [3:0]  o_wr_mask;

  always #5 clk = ~clk;

  asrv32_lsu #(.TIMEOUT_CYCLES(TC)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ready(o_ready), .o_done(o_done), .o_rdata(o_rdata),
    .o_misaligned(o_misaligned), .o_timeout(o_timeout),
    .o_stb_data(o_stb_data), .o_data_addr(o_data_addr), .o_wdata(o_wdata),
    .o_wr_en(o_wr_en), .o_wr_mask(o_wr_mask), .i_rdata(i_rdata),
    .i_ack_data(i_ack_data)
  );

  int checks = 0;
  int errors = 0;

  // Responder state: mode 0 never acks, 1 acks one cycle after stb, 2 acks
  // in the stb cycle itself.
  int          mode = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_rdata = 32'h0;
  logic        stray_ack = 1'b0;
  logic [31:0] stray_rdata = 32'h1234_5678;
  logic [31:0] mem [16];

  int lat, stbs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs and the responder update 1 time unit after the edge.
  task automatic tick();
    logic [3:0] idx;
    @(posedge clk);
    #1;
    if (mode == 2) begin
      i_ack_data = o_stb_data | stray_ack;
      i_rdata    = o_stb_data ? mem[o_data_addr[5:2]] : stray_rdata;
    end else begin
      i_ack_data = (mode == 1 && pend) | stray_ack;
      i_rdata    = (mode == 1 && pend) ? pend_rdata : stray_rdata;
    end
    pend = (mode == 1) && o_stb_data;
    if (mode != 0 && o_stb_data) begin
      idx        = o_data_addr[5:2];
      pend_rdata = mem[idx];
      if (o_wr_en)
        for (int b = 0; b < 4; b++)
          if (o_wr_mask[b]) mem[idx][8*b +: 8] = o_wdata[8*b +: 8];
    end
  endtask

  // Present one request, then run until o_done (bounded); lat is cycles from
  // accept to the o_done cycle, stbs counts strobe cycles seen on the way.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat_o, output int stbs_o);
    i_req = 1'b1; i_we = we; i_size = size; i_unsigned = uns;
    i_addr = addr; i_wdata = wdata;
    tick();
    i_req = 1'b0;
    lat_o = 1; stbs_o = 0;
    while (!o_done && lat_o < 20) begin
      if (o_stb_data) stbs_o++;
      tick();
      lat_o++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h8001_1234;

    // Reset state
    tick(); tick();
    check("rst_done",   32'(o_done), 0);
    check("rst_stb",    32'(o_stb_data), 0);
    check("rst_wr_en",  32'(o_wr_en), 0);
    check("rst_mask",   32'(o_wr_mask), 0);
    check("rst_rdata",  o_rdata, 0);
    check("rst_wdata",  o_wdata, 0);
    check("rst_addr",   o_data_addr, 0);
    check("rst_flags",  32'({o_misaligned, o_timeout}), 0);
    i_rst = 1'b0;
    tick();
    check("rst_ready",  32'(o_ready), 1);

    // Byte store 0xA5 to 0x6, registered-ack RAM
    mode = 1;
    i_req = 1'b1; i_we = 1'b1; i_size = SIZE_BYTE; i_unsigned = 1'b0;
    i_addr = 32'h0000_0006; i_wdata = 32'h0000_00A5;
    tick();
    i_req = 1'b0;
    check("sb_t1_stb",   32'(o_stb_data), 1);
    check("sb_t1_addr",  o_data_addr, 32'h0000_0004);
    check("sb_t1_mask",  32'(o_wr_mask), 32'h4);
    check("sb_t1_wdata", o_wdata, 32'hA5A5_A5A5);
    check("sb_t1_wr_en", 32'(o_wr_en), 1);
    check("sb_t1_ready", 32'(o_ready), 0);
    tick();
    check("sb_t2_stb",   32'(o_stb_data), 0);
    check("sb_t2_mask",  32'(o_wr_mask), 0);
    check("sb_t2_wr_en", 32'(o_wr_en), 0);
    check("sb_t2_done",  32'(o_done), 0);
    tick();
    check("sb_t3_done",  32'(o_done), 1);
    check("sb_t3_ready", 32'(o_ready), 1);
    check("sb_t3_flags", 32'({o_misaligned, o_timeout}), 0);
    check("sb_t3_rdata", o_rdata, 0);
    check("sb_mem",      mem[1], 32'h00A5_0000);

    // Load extraction from word 0 = 0x8001_1234
    access(1'b0, SIZE_HALF, 1'b0, 32'h2, 32'h0, lat, stbs);
    check("lh2_lat",   32'(lat), 3);
    check("lh2_data",  o_rdata, 32'hFFFF_8001);
    access(1'b0, SIZE_HALF, 1'b1, 32'h2, 32'h0, lat, stbs);
    check("lhu2_data", o_rdata, 32'h0000_8001);
    access(1'b0, SIZE_BYTE, 1'b0, 32'h1, 32'h0, lat, stbs);
    check("lb1_data",  o_rdata, 32'h0000_0012);
    access(1'b0, SIZE_BYTE, 1'b0, 32'h3, 32'h0, lat, stbs);
    check("lb3_data",  o_rdata, 32'hFFFF_FF80);
    access(1'b0, SIZE_BYTE, 1'b1, 32'h3, 32'h0, lat, stbs);
    check("lbu3_data", o_rdata, 32'h0000_0080);
    check("lbu3_stbs", 32'(stbs), 1);

    // Misaligned word at 0x1 and half at 0x3
    access(1'b0, SIZE_WORD, 1'b0, 32'h1, 32'h0, lat, stbs);
    check("mis_w_lat",   32'(lat), 1);
    check("mis_w_flag",  32'(o_misaligned), 1);
    check("mis_w_stb",   32'(o_stb_data), 0);
    check("mis_w_rdata", o_rdata, 32'h0000_0080);
    check("mis_w_ready", 32'(o_ready), 1);
    tick();
    check("mis_w_pulse", 32'({o_done, o_misaligned, o_stb_data}), 0);
    access(1'b1, SIZE_HALF, 1'b0, 32'h3, 32'hFFFF, lat, stbs);
    check("mis_h_lat",   32'(lat), 1);
    check("mis_h_flag",  32'(o_misaligned), 1);
    tick();
    check("mis_h_stb",   32'(o_stb_data), 0);

    // Timeout with a responder that never acks
    mode = 0;
    access(1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, lat, stbs);
    check("to_lat",    32'(lat), TC + 2);
    check("to_stbs",   32'(stbs), 1);
    check("to_flag",   32'(o_timeout), 1);
    check("to_mis",    32'(o_misaligned), 0);
    check("to_rdata",  o_rdata, 32'h0000_0080);
    check("to_ready",  32'(o_ready), 1);

    // Combinational responder: ack in the REQ cycle
    mode = 2;
    access(1'b0, SIZE_WORD, 1'b0, 32'h4, 32'h0, lat, stbs);
    check("comb_lat",  32'(lat), 2);
    check("comb_data", o_rdata, 32'h00A5_0000);

    // Back-to-back store/load/store/load against the registered RAM
    mode = 1;
    access(1'b1, SIZE_WORD, 1'b0, 32'h8, 32'hDEAD_BEEF, lat, stbs);
    check("b2b_sw_lat",  32'(lat), 3);
    check("b2b_sw_rd",   o_rdata, 32'h00A5_0000);
    access(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, lat, stbs);
    check("b2b_lw_lat",  32'(lat), 3);
    check("b2b_lw_data", o_rdata, 32'hDEAD_BEEF);
    access(1'b1, SIZE_HALF, 1'b0, 32'hA, 32'h0000_CAFE, lat, stbs);
    check("b2b_sh_lat",  32'(lat), 3);
    access(1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0, lat, stbs);
    check("b2b_lw2",     o_rdata, 32'hCAFE_BEEF);
    access(1'b0, SIZE_HALF, 1'b1, 32'hA, 32'h0, lat, stbs);
    check("b2b_lhu",     o_rdata, 32'h0000_CAFE);

    // Stray ack while idle
    mode = 0;
    stray_ack = 1'b1;
    tick(); tick();
    check("stray_done",  32'(o_done), 0);
    tick();
    check("stray_done2", 32'(o_done), 0);
    check("stray_rdata", o_rdata, 32'h0000_CAFE);
    check("stray_ready", 32'(o_ready), 1);
    stray_ack = 1'b0;
    tick();

    // Reset during WAIT, late ack, then a normal access
    i_req = 1'b1; i_we = 1'b0; i_size = SIZE_WORD; i_addr = 32'h8;
    tick();
    i_req = 1'b0;
    tick();
    check("rw_wait_ready", 32'(o_ready), 0);
    i_rst = 1'b1;
    tick();
    check("rw_ready",  32'(o_ready), 1);
    check("rw_outs",   32'({o_done, o_misaligned, o_timeout, o_stb_data, o_wr_en, o_wr_mask}), 0);
    check("rw_rdata",  o_rdata, 0);
    check("rw_addr",   o_data_addr, 0);
    i_rst = 1'b0;
    stray_ack = 1'b1;
    tick(); tick();
    check("rw_late_done", 32'(o_done), 0);
    stray_ack = 1'b0;
    tick();
    check("rw_late_done2", 32'(o_done), 0);
    mode = 1;
    access(1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0, lat, stbs);
    check("rw_next_lat",  32'(lat), 3);
    check("rw_next_data", o_rdata, 32'hCAFE_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
